// File: rtl/uart_autobaud.sv
// UART auto-baud: times eight bit periods of a 0x55 sync character and reports divisor = period - 1.
// valid pulses 1 cycle after the 5th fall on rx_s (3 cycles from the pin); no backpressure, start ignored while busy.
module uart_autobaud #(
  parameter logic [11:0] DEFAULT_DIV = 12'd433,
  parameter int          IDLE_CYCLES = 16,
  parameter logic [14:0] TIMEOUT     = 15'h7fff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        uart_read,
  output logic [11:0] divisor,
  output logic        valid,
  output logic        busy,
  output logic        error
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_START, MEASURE, DONE} state_t;

  state_t          state;
  logic            rx_m, rx_s, rx_d;
  logic            fall;
  logic [IW-1:0]   idle_cnt;
  logic [14:0]     cnt;
  logic [2:0]      fall_cnt;
  logic [12:0]     period;
  logic            period_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_read;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // Rounded bit period from the live counter, so the result registers on the 5th fall itself.
  assign period    = 13'(({1'b0, cnt} + 16'd4) >> 3);
  assign period_ok = (period >= 13'd2) && (period <= 13'd4096);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      divisor  <= DEFAULT_DIV;
      valid    <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      idle_cnt <= '0;
      cnt      <= '0;
      fall_cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            error    <= 1'b0;
            idle_cnt <= '0;
          end
        end
        ARM: begin
          if (rx_s) begin
            if (idle_cnt == IW'(IDLE_CYCLES - 1)) state <= WAIT_START;
            idle_cnt <= idle_cnt + 1'b1;
          end else begin
            idle_cnt <= '0;
          end
        end
        WAIT_START: begin
          if (fall) begin
            state    <= MEASURE;
            cnt      <= 15'd1;
            fall_cnt <= 3'd1;
          end
        end
        MEASURE: begin
          cnt <= cnt + 1'b1;
          if (fall) fall_cnt <= fall_cnt + 1'b1;
          if (fall && fall_cnt == 3'd4) begin
            state <= DONE;
            if (period_ok) begin
              // period 4096 wraps to 0 in 12 bits, so the subtraction still yields 4095.
              divisor <= period[11:0] - 12'd1;
              valid   <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end else if (cnt == TIMEOUT) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: table of sync-character bit periods plus hand-written corner sequences.
module tb_uart_autobaud;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        uart_read = 1'b1;
  logic [11:0] divisor;
  logic        valid;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  uart_autobaud dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .uart_read(uart_read),
    .divisor  (divisor),
    .valid    (valid),
    .busy     (busy),
    .error    (error)
  );

  typedef struct {
    int period;
    int exp_div;
    int exp_err;
  } vec_t;

  vec_t vecs[7];

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int proto_bad = 0;
  int div_glitch = 0;
  logic        prev_valid = 1'b0;
  logic        chk_busy_next = 1'b0;
  logic        prev_reset = 1'b0;
  logic [11:0] prev_div = 12'd0;

  // Pulse protocol: valid one cycle wide, busy high with valid and low the cycle after;
  // divisor must only move in a valid cycle (reset excluded).
  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      if (!busy) proto_bad++;
      if (prev_valid) proto_bad++;
    end
    if (chk_busy_next && busy) proto_bad++;
    chk_busy_next = valid;
    if (reset && prev_reset && !valid && divisor !== prev_div) div_glitch++;
    prev_valid = valid;
    prev_div   = divisor;
    prev_reset = reset;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input int p);
    uart_read = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      uart_read = c[i];
      tick(p);
    end
    uart_read = 1'b1;
    tick(p);
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < bound) begin
      tick(1);
      cyc++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin
    int v0;
    int cyc;

    vecs[0] = '{434, 433, 0};
    vecs[1] = '{8,   7,   0};
    vecs[2] = '{1,   7,   1};
    vecs[3] = '{2,   1,   0};
    vecs[4] = '{3,   2,   0};
    vecs[5] = '{100, 99,  0};
    vecs[6] = '{13,  12,  0};

    tick(3);
    check("rst_divisor", int'(divisor), 433);
    check("rst_valid",   int'(valid),   0);
    check("rst_busy",    int'(busy),    0);
    check("rst_error",   int'(error),   0);
    reset = 1'b1;
    tick(2);

    for (int k = 0; k < 7; k++) begin
      v0 = valid_cnt;
      pulse_start();
      tick(20);
      send_char(8'h55, vecs[k].period);
      tick(4);
      wait_idle(100, cyc);
      check($sformatf("vec%0d_divisor", k), int'(divisor), vecs[k].exp_div);
      check($sformatf("vec%0d_error", k),   int'(error),   vecs[k].exp_err);
      check($sformatf("vec%0d_valids", k),  valid_cnt - v0, vecs[k].exp_err ? 0 : 1);
    end

    // Start while the line is low: ARM must see 16 consecutive highs before arming.
    v0 = valid_cnt;
    uart_read = 1'b0;
    tick(2);
    pulse_start();
    tick(100);
    check("arm_low_busy", int'(busy), 1);
    uart_read = 1'b1;
    tick(10);
    uart_read = 1'b0;
    tick(30);
    check("arm_short_high_busy", int'(busy), 1);
    uart_read = 1'b1;
    tick(20);
    send_char(8'h55, 8);
    tick(4);
    wait_idle(100, cyc);
    check("arm_divisor", int'(divisor), 7);
    check("arm_valids",  valid_cnt - v0, 1);

    // Start pulsed mid-measurement is ignored.
    v0 = valid_cnt;
    pulse_start();
    tick(20);
    fork
      send_char(8'h55, 20);
      begin
        tick(50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
    join
    tick(4);
    wait_idle(100, cyc);
    check("midstart_divisor", int'(divisor), 19);
    check("midstart_error",   int'(error),   0);
    check("midstart_valids",  valid_cnt - v0, 1);

    // Reset after the 3rd fall abandons the measurement.
    pulse_start();
    tick(20);
    fork
      send_char(8'h55, 10);
      begin
        tick(45);
        #2 reset = 1'b0;
        #1;
        check("midrst_divisor", int'(divisor), 433);
        check("midrst_busy",    int'(busy),    0);
        check("midrst_valid",   int'(valid),   0);
        check("midrst_error",   int'(error),   0);
      end
    join
    reset = 1'b1;
    tick(2);
    v0 = valid_cnt;
    send_char(8'h55, 8);
    tick(5);
    check("postrst_busy",    int'(busy),    0);
    check("postrst_valids",  valid_cnt - v0, 0);
    check("postrst_divisor", int'(divisor), 433);

    // 0x00 gives a single fall, so the counter runs to TIMEOUT.
    v0 = valid_cnt;
    pulse_start();
    tick(20);
    uart_read = 1'b0;
    tick(36);
    uart_read = 1'b1;
    wait_idle(40000, cyc);
    check("timeout_cycles",  cyc + 36, 32770);
    check("timeout_error",   int'(error),   1);
    check("timeout_divisor", int'(divisor), 433);
    check("timeout_valids",  valid_cnt - v0, 0);

    check("valid_busy_protocol", proto_bad,  0);
    check("divisor_stability",   div_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
